// File: rtl/if_fetch_unit_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction memory (slave).
// Carries the request handshake (valid/ready/addr) and the in-order response (valid/data).
interface if_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues in-order requests to instruction
// memory, buffers returned words with their PCs and presents the buffer head to decode.
// Redirects flush the buffer and discard responses still in flight.
// Optional feature: define FETCH_PERF_EN to add the perf_fetched / perf_bubbles counters.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    if_fetch_unit_if.master imem,
    input  logic            redirect_valid,
    input  logic [31:0]     redirect_pc,
    input  logic            stall_ID,
    output logic [31:0]     inst_IF,
    output logic [31:0]     PC_IF,
    output logic            inst_valid_IF
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_bubbles
`endif
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_SUM = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t             r_state;
    state_t             w_stateNext;
    logic [31:0]        r_pc;
    logic [CNT_W-1:0]   r_inflight;
    logic [CNT_W-1:0]   w_inflightNext;
    logic [CNT_W-1:0]   r_discard;
    logic [CNT_W-1:0]   w_discardNext;
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [PTR_W-1:0]   r_wrPtr;
    logic [31:0]        r_bufInst [FIFO_DEPTH];
    logic [31:0]        r_bufPc   [FIFO_DEPTH];
    logic [CNT_W:0]     w_credit;
    logic               w_reqValid;
    logic               w_accept;
    logic               w_rspValid;
    logic               w_push;
    logic               w_pop;
    logic               w_instValid;
    logic [31:0]        w_oldestPc;
    logic [31:0]        w_redirectTarget;

    // Request side: issue only in RUN, never on a redirect cycle, and only while buffer
    // slots outnumber words already owed to us, so a response can always be stored.
    always_comb begin
        w_credit   = {1'b0, r_inflight} + {1'b0, r_count};
        w_reqValid = rst_n & (r_state == ST_RUN) & ~redirect_valid & (w_credit < DEPTH_SUM);
        w_accept   = w_reqValid & imem.imem_req_ready;
    end

    assign imem.imem_req_valid = w_reqValid;
    assign imem.imem_req_addr  = r_pc;

    // Response bookkeeping: in-flight requests are always a contiguous run ending just
    // below the fetch PC, so the oldest one's PC is recovered from the in-flight count.
    always_comb begin
        w_rspValid       = imem.imem_rsp_valid;
        w_push           = w_rspValid & (r_state == ST_RUN) & ~redirect_valid;
        w_oldestPc       = r_pc - (32'(r_inflight) << 2);
        w_inflightNext   = r_inflight + CNT_W'(w_accept) - CNT_W'(w_rspValid);
        w_redirectTarget = redirect_pc & 32'hFFFF_FFFC;
        w_discardNext    = r_discard;
        if (redirect_valid) begin
            w_discardNext = w_inflightNext;
        end else if ((r_state == ST_DRAIN) && w_rspValid) begin
            w_discardNext = r_discard - CNT_W'(1);
        end
    end

    // Next-state logic: drain stale responses after a redirect before fetching again.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: begin
                w_stateNext = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_valid && (w_inflightNext != '0)) begin
                    w_stateNext = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_discardNext == '0) begin
                    w_stateNext = ST_RUN;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Fetch PC, in-flight and discard counters; a redirect overrides sequential advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_inflight <= '0;
            r_discard  <= '0;
        end else begin
            r_inflight <= w_inflightNext;
            r_discard  <= w_discardNext;
            if (redirect_valid) begin
                r_pc <= w_redirectTarget;
            end else if (w_accept) begin
                r_pc <= r_pc + 32'd4;
            end
        end
    end

    // Fetch-buffer pointers and occupancy; a redirect empties it on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else if (redirect_valid) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Fetch-buffer storage; contents are only visible while occupancy is non-zero.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_bufInst[r_wrPtr] <= imem.imem_rsp_data;
            r_bufPc[r_wrPtr]   <= w_oldestPc;
        end
    end

    // Head of the buffer drives decode directly; an empty buffer shows a NOP at PC 0.
    always_comb begin
        w_instValid   = rst_n & (r_count != '0);
        w_pop         = w_instValid & ~stall_ID;
        inst_valid_IF = w_instValid;
        inst_IF       = w_instValid ? r_bufInst[r_rdPtr] : NOP_INST;
        PC_IF         = w_instValid ? r_bufPc[r_rdPtr] : 32'h0000_0000;
    end

`ifdef FETCH_PERF_EN
    // Counters of delivered instructions and of RUN cycles where decode sat waiting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (w_pop) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if ((r_state == ST_RUN) && !w_instValid && !stall_ID) begin
                perf_bubbles <= perf_bubbles + 32'd1;
            end
        end
    end
`endif

endmodule
